// File: rtl/mycpu_io.sv
// mycpu_io: IO-space responder for the mycpu core bus.
// GPIO out/in, a down-counting timer with irq, and a byte TX FIFO.
module mycpu_io #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a_in,
    input  logic [15:0] d_in,
    input  logic        wen_in,
    input  logic        iom_in,
    output logic [15:0] io_out,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic        timer_irq_out,
    output logic [7:0]  tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int SPAD = 13 - CW;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // Register state
    logic [15:0]   gpio_q;
    logic [15:0]   sync1_q, sync2_q;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   load_q, load_d;
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          exp_q, exp_d;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          ovf_q, ovf_d;

    logic [2:0]    idx;
    logic [7:0]    wsel;
    logic          empty, full, push, pop;
    logic [15:0]   status;
    logic          unused_a;

    assign idx      = a_in[2:0];
    assign unused_a = ^a_in[15:3];
    assign wsel     = {8{wen_in & iom_in}} & (8'b1 << idx);

    assign empty  = (fcnt_q == '0);
    assign full   = (fcnt_q == FULL_C);
    assign push   = wsel[5] & ~full;
    assign pop    = ~empty & tx_ready_in;
    assign status = {{SPAD{1'b0}}, fcnt_q, ovf_q, full, empty};

    assign gpio_out      = gpio_q;
    assign timer_irq_out = exp_q;
    assign tx_data_out   = mem_q[rd_ptr_q];
    assign tx_valid_out  = ~empty;

    // Combinational read mux; no side effects
    always_comb begin
        io_out = '0;
        case (idx)
            3'd0:    io_out = gpio_q;
            3'd1:    io_out = sync2_q;
            3'd2:    io_out = cnt_q;
            3'd3:    io_out = load_q;
            3'd4:    io_out = {exp_q, 13'b0, auto_q, en_q};
            3'd5:    io_out = status;
            default: io_out = '0;
        endcase
    end

    // Timer next state: load write beats tick, expiry set beats clear
    always_comb begin
        cnt_d  = cnt_q;
        load_d = load_q;
        en_d   = en_q;
        auto_d = auto_q;
        exp_d  = exp_q;
        if (en_q) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else if (auto_q) begin
                cnt_d = load_q;
            end else begin
                en_d = 1'b0;
            end
        end
        if (wsel[4]) begin
            en_d   = d_in[0];
            auto_d = d_in[1];
            if (d_in[15]) exp_d = 1'b0;
        end
        if (en_q && cnt_q == 16'd0) exp_d = 1'b1;
        if (wsel[3]) begin
            load_d = d_in;
            cnt_d  = d_in;
        end
    end

    // FIFO occupancy and sticky overflow
    always_comb begin
        fcnt_d = fcnt_q;
        ovf_d  = ovf_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        if (wsel[5] && full) ovf_d = 1'b1;
        if (wsel[6] && d_in[0]) ovf_d = 1'b0;
    end

    // GPIO, synchronizer and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            load_q  <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            if (wsel[0]) gpio_q <= d_in;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
        end
    end

    // FIFO storage, pointers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= d_in[7:0];
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mycpu_io.sv
// tb_mycpu_io: self-checking bench for mycpu_io.
// FIFO bytes are tracked through a scoreboard queue.
module tb_mycpu_io;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] d_in = '0;
    logic        wen_in = 1'b0;
    logic        iom_in = 1'b0;
    logic [15:0] io_out;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic        timer_irq_out;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] sb [$];
    bit movf = 1'b0;

    mycpu_io #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_in(a_in), .d_in(d_in),
        .wen_in(wen_in), .iom_in(iom_in),
        .io_out(io_out), .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .timer_irq_out(timer_irq_out),
        .tx_data_out(tx_data_out),
        .tx_valid_out(tx_valid_out),
        .tx_ready_in(tx_ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] st(int n, bit ovf);
        logic [15:0] v;
        v = 16'(n << 3);
        if (ovf) v = v | 16'h4;
        if (n == DEPTH) v = v | 16'h2;
        if (n == 0) v = v | 16'h1;
        return v;
    endfunction

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input logic iom);
        @(negedge clk);
        a_in = a; d_in = d; wen_in = 1'b1; iom_in = iom;
        @(posedge clk);
        #1;
        wen_in = 1'b0; iom_in = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr(16'd5, {8'h00, b}, 1'b1);
        if (sb.size() < DEPTH) sb.push_back(b);
        else movf = 1'b1;
    endtask

    task automatic test_reset;
        vectors++;
        if ({gpio_out, tx_valid_out, tx_data_out, timer_irq_out} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h/%b/%h/%b want 0",
                     gpio_out, tx_valid_out, tx_data_out, timer_irq_out);
        end
        a_in = 16'd5; #1;
        vectors++;
        if (io_out !== st(0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_status got %h want %h", io_out, st(0, 1'b0));
        end
        a_in = 16'd4; #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %h want 0000", io_out);
        end
    endtask

    task automatic test_gpio;
        wr(16'd0, 16'hA5C3, 1'b1);
        a_in = 16'd0; #1;
        vectors++;
        if (io_out !== 16'hA5C3 || gpio_out !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL gpio_out got %h/%h want a5c3", io_out, gpio_out);
        end
        @(negedge clk);
        gpio_in = 16'h1234;
        a_in = 16'd1;
        @(posedge clk); #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL gpio_in_1edge got %h want 0000", io_out);
        end
        @(posedge clk); #1;
        vectors++;
        if (io_out !== 16'h1234) begin
            miscompares++;
            $display("FAIL gpio_in_2edge got %h want 1234", io_out);
        end
    endtask

    task automatic test_decode;
        wr(16'h0008, 16'h5A5A, 1'b1);
        vectors++;
        if (gpio_out !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL alias_write got %h want 5a5a", gpio_out);
        end
        wr(16'h0000, 16'hFFFF, 1'b0);
        vectors++;
        if (gpio_out !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL iom0_write got %h want 5a5a", gpio_out);
        end
        wr(16'h0002, 16'h1234, 1'b1);
        wr(16'h0007, 16'hFFFF, 1'b1);
        a_in = 16'd2; #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL cnt_ro got %h want 0000", io_out);
        end
        a_in = 16'd7; #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reg7 got %h want 0000", io_out);
        end
        a_in = 16'd6; #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reg6 got %h want 0000", io_out);
        end
    endtask

    task automatic test_oneshot;
        wr(16'd3, 16'd3, 1'b1);
        wr(16'd4, 16'h0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a_in = 16'd2; #1;
            vectors++;
            if (io_out !== 16'(3 - i) || timer_irq_out !== 1'b0) begin
                miscompares++;
                $display("FAIL oneshot_cnt%0d got %h/%b want %h/0",
                         i, io_out, timer_irq_out, 16'(3 - i));
            end
            @(posedge clk); #1;
        end
        a_in = 16'd4; #1;
        vectors++;
        if (io_out !== 16'h8000 || timer_irq_out !== 1'b1) begin
            miscompares++;
            $display("FAIL oneshot_expire got %h/%b want 8000/1",
                     io_out, timer_irq_out);
        end
        @(posedge clk); #1;
        a_in = 16'd2; #1;
        vectors++;
        if (io_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL oneshot_hold got %h want 0000", io_out);
        end
        wr(16'd4, 16'h8000, 1'b1);
        vectors++;
        if (timer_irq_out !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear got %b want 0", timer_irq_out);
        end
    endtask

    task automatic test_auto;
        logic [15:0] exp_c [4] = '{16'd2, 16'd1, 16'd0, 16'd2};
        logic        exp_i [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        wr(16'd3, 16'd2, 1'b1);
        wr(16'd4, 16'h0003, 1'b1);
        for (int i = 0; i < 4; i++) begin
            a_in = 16'd2; #1;
            vectors++;
            if (io_out !== exp_c[i] || timer_irq_out !== exp_i[i]) begin
                miscompares++;
                $display("FAIL auto_cyc%0d got %h/%b want %h/%b",
                         i, io_out, timer_irq_out, exp_c[i], exp_i[i]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        wr(16'd4, 16'h8003, 1'b1);
        a_in = 16'd2; #1;
        vectors++;
        if (io_out !== 16'd1 || timer_irq_out !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_clr got %h/%b want 0001/0",
                     io_out, timer_irq_out);
        end
        @(posedge clk); #1;
        wr(16'd4, 16'h8003, 1'b1);
        a_in = 16'd2; #1;
        vectors++;
        if (io_out !== 16'd2 || timer_irq_out !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clr got %h/%b want 0002/1",
                     io_out, timer_irq_out);
        end
        wr(16'd4, 16'h8000, 1'b1);
    endtask

    task automatic test_fifo_fill;
        logic [7:0] e;
        tx_ready_in = 1'b0;
        for (int i = 1; i <= 5; i++) push_byte(8'(i * 16'h11));
        a_in = 16'd5; #1;
        vectors++;
        if (io_out !== st(sb.size(), movf) || io_out !== 16'h0026) begin
            miscompares++;
            $display("FAIL fill_status got %h want %h",
                     io_out, st(sb.size(), movf));
        end
        @(negedge clk);
        tx_ready_in = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            vectors++;
            if (tx_valid_out !== 1'b1 || tx_data_out !== e) begin
                miscompares++;
                $display("FAIL drain_byte got %b/%h want 1/%h",
                         tx_valid_out, tx_data_out, e);
            end
            @(negedge clk);
        end
        vectors++;
        if (tx_valid_out !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_end got valid %b left %0d want 0/0",
                     tx_valid_out, sb.size());
        end
        tx_ready_in = 1'b0;
        wr(16'd6, 16'h0001, 1'b1);
        movf = 1'b0;
        a_in = 16'd5; #1;
        vectors++;
        if (io_out !== st(0, movf)) begin
            miscompares++;
            $display("FAIL ovf_clear got %h want %h", io_out, st(0, movf));
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        tx_ready_in = 1'b0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        @(negedge clk);
        tx_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_in = 16'd5; d_in = 16'(8'hA3 + i);
            wen_in = 1'b1; iom_in = 1'b1;
            #1;
            vectors++;
            if (io_out !== st(sb.size(), movf) || sb.size() != 2) begin
                miscompares++;
                $display("FAIL b2b_status%0d got %h want %h",
                         i, io_out, st(sb.size(), movf));
            end
            e = sb.pop_front();
            vectors++;
            if (tx_valid_out !== 1'b1 || tx_data_out !== e) begin
                miscompares++;
                $display("FAIL b2b_byte%0d got %b/%h want 1/%h",
                         i, tx_valid_out, tx_data_out, e);
            end
            sb.push_back(8'(8'hA3 + i));
            @(negedge clk);
        end
        wen_in = 1'b0; iom_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sb.size() == 0) break;
            e = sb.pop_front();
            vectors++;
            if (tx_valid_out !== 1'b1 || tx_data_out !== e) begin
                miscompares++;
                $display("FAIL b2b_drain got %b/%h want 1/%h",
                         tx_valid_out, tx_data_out, e);
            end
            @(negedge clk);
        end
        vectors++;
        if (tx_valid_out !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_end got valid %b left %0d want 0/0",
                     tx_valid_out, sb.size());
        end
        tx_ready_in = 1'b0;
    endtask

    task automatic test_reset_mid;
        wr(16'd0, 16'hBEEF, 1'b1);
        wr(16'd3, 16'd100, 1'b1);
        wr(16'd4, 16'h0001, 1'b1);
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        movf = 1'b0;
        vectors++;
        if ({gpio_out, tx_valid_out, tx_data_out, timer_irq_out} !== 26'd0) begin
            miscompares++;
            $display("FAIL rst_mid_out got %h/%b/%h/%b want 0",
                     gpio_out, tx_valid_out, tx_data_out, timer_irq_out);
        end
        a_in = 16'd5; #1;
        vectors++;
        if (io_out !== st(sb.size(), movf)) begin
            miscompares++;
            $display("FAIL rst_mid_status got %h want %h",
                     io_out, st(sb.size(), movf));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        a_in = 16'd2; #1;
        vectors++;
        if (io_out !== 16'h0000 || tx_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_after got %h/%b want 0000/0",
                     io_out, tx_valid_out);
        end
    endtask

    initial begin
        #1;
        test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_gpio;
        test_decode;
        test_oneshot;
        test_auto;
        test_fifo_fill;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
